grid_clb_param: RTL



---
 rtl/grid_clb_param.sv | 123 ++++++++++++
 1 files changed

// File: rtl/grid_clb_param.sv
// Parametrised CLB tile: N BLEs, each a K-input LUT with bypassable FF, fed by a per-input crossbar over clb_I and registered BLE outputs.
// Latency: 0 cycles combinational mode, 1 cycle registered mode; config is a serial shift chain, ccff_tail registered. No backpressure: outputs gated to 0 until a correct-length load.
// Optional GRID_CLB_CE_EN adds a ce input that gates BLE flip-flop updates.
module grid_clb_param #(
    parameter int K = 4,
    parameter int N = 2,
    parameter int I = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_en,
    input  logic         ccff_head,
    input  logic [I-1:0] clb_I,
`ifdef GRID_CLB_CE_EN
    input  logic         ce,
`endif
    output logic [N-1:0] clb_O,
    output logic         ccff_tail,
    output logic         cfg_done,
    output logic         cfg_err
);
    localparam int S        = $clog2(I + N);
    localparam int T        = 1 << K;
    localparam int BB       = T + 1 + K * S;
    localparam int CFG_BITS = N * BB;
    localparam int CW       = $clog2(CFG_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CFG_BITS + 1);

    typedef enum logic [1:0] {
        ST_UNCONFIG,
        ST_LOADING,
        ST_ACTIVE,
        ST_ERROR
    } state_t;

    state_t                state;
    logic [CFG_BITS-1:0]   chain;
    logic [CW-1:0]         cnt;
    logic [N-1:0]          ff;
    logic [N-1:0]          lut_o;
    logic [I+N-1:0]        src;
    logic [S-1:0]          sel;
    logic [K-1:0]          idx;
    logic [T-1:0]          tbl;
    logic                  ff_upd;

`ifdef GRID_CLB_CE_EN
    assign ff_upd = ce;
`else
    assign ff_upd = 1'b1;
`endif

    // Feedback taps the registered FFs only, so the crossbar can never form a loop.
    always_comb begin
        src   = {ff, clb_I};
        sel   = '0;
        idx   = '0;
        tbl   = '0;
        lut_o = '0;
        for (int n = 0; n < N; n++) begin
            for (int k = 0; k < K; k++) begin
                sel    = chain[n*BB + T + 1 + k*S +: S];
                idx[k] = (int'(sel) < I + N) ? src[sel] : 1'b0;
            end
            tbl      = chain[n*BB +: T];
            lut_o[n] = tbl[idx];
        end
    end

    always_comb begin
        clb_O = '0;
        for (int n = 0; n < N; n++) begin
            if (state == ST_ACTIVE)
                clb_O[n] = chain[n*BB + T] ? ff[n] : lut_o[n];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain     <= '0;
            ccff_tail <= 1'b0;
            ff        <= '0;
            cnt       <= '0;
            state     <= ST_UNCONFIG;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            if (cfg_en) begin
                chain     <= {chain[CFG_BITS-2:0], ccff_head};
                ccff_tail <= chain[CFG_BITS-1];
            end
            case (state)
                ST_LOADING: begin
                    if (cfg_en) begin
                        if (cnt != CNT_MAX)
                            cnt <= cnt + 1'b1;
                    end else if (cnt == CNT_FULL) begin
                        state    <= ST_ACTIVE;
                        cfg_done <= 1'b1;
                        cfg_err  <= 1'b0;
                    end else begin
                        state    <= ST_ERROR;
                        cfg_done <= 1'b0;
                        cfg_err  <= 1'b1;
                    end
                end
                default: begin
                    // Any new load restarts the count and drops the tile out of service.
                    if (cfg_en) begin
                        state    <= ST_LOADING;
                        cnt      <= CW'(1);
                        cfg_done <= 1'b0;
                        cfg_err  <= 1'b0;
                        ff       <= '0;
                    end else if (state == ST_ACTIVE && ff_upd) begin
                        ff <= lut_o;
                    end
                end
            endcase
        end
    end
endmodule
